uart_tx_sequencer: RTL and testbench

//  System-side driver for the UART transmitter's data_valid/parallel_data/busy handshake.
//  - Accepts one multi-byte word from the system core per valid/ready handshake.
//  - Sends the word byte by byte into the UART transmitter, LSB byte first.
//  - Waits for the transmitter to finish each byte before issuing the next.
//  - Flags a transmitter that never accepts a byte.

---
 rtl/uart_tx_sequencer.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// ============================================================================
// uart_tx_sequencer: feeds valid/ready words into a UART transmitter, LSB byte first
// Rev 1.0 | optional trailing XOR checksum byte enabled by UART_TX_SEQ_CHECKSUM_EN
// ============================================================================
`default_nettype none

module uart_tx_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_BYTES      = 2,
  parameter int ACCEPT_TIMEOUT = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH*NUM_BYTES-1:0] in_data,
  output logic                            tx_data_valid,
  output logic [DATA_WIDTH-1:0]           tx_parallel_data,
  input  logic                            tx_busy,
  output logic                            frame_done,
  output logic                            timeout_error
);

  localparam int WORD_W = DATA_WIDTH * NUM_BYTES;
  localparam int CNT_W  = $clog2(NUM_BYTES + 1);
  localparam int TMR_W  = $clog2(ACCEPT_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND        = 2'd1,
    WAIT_ACCEPT = 2'd2,
    WAIT_DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [WORD_W-1:0]       shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    tmo_q, tmo_d;
`ifdef UART_TX_SEQ_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   xor_q, xor_d;
  logic                    chk_q, chk_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
`ifdef UART_TX_SEQ_CHECKSUM_EN
      xor_q   <= '0;
      chk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
`ifdef UART_TX_SEQ_CHECKSUM_EN
      xor_q   <= xor_d;
      chk_q   <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    data_d  = data_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
`ifdef UART_TX_SEQ_CHECKSUM_EN
    xor_d   = xor_q;
    chk_d   = chk_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          shift_d = in_data;
          cnt_d   = CNT_W'(NUM_BYTES);
          state_d = SEND;
`ifdef UART_TX_SEQ_CHECKSUM_EN
          xor_d   = '0;
          chk_d   = 1'b0;
`endif
        end
      end
      SEND: begin
        timer_d = '0;
        state_d = WAIT_ACCEPT;
`ifdef UART_TX_SEQ_CHECKSUM_EN
        if (!chk_q) begin
          xor_d = xor_q ^ data_q;
        end
`endif
      end
      WAIT_ACCEPT: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TMR_W'(ACCEPT_TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef UART_TX_SEQ_CHECKSUM_EN
          if (chk_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_d == '0) begin
              chk_d   = 1'b1;
              state_d = SEND;
            end else begin
              shift_d = shift_q >> DATA_WIDTH;
              state_d = SEND;
            end
          end
`else
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_d == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            shift_d = shift_q >> DATA_WIDTH;
            state_d = SEND;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so the byte and strobe are loaded on the edge entering SEND.
    if (state_d == SEND) begin
      valid_d = 1'b1;
`ifdef UART_TX_SEQ_CHECKSUM_EN
      data_d  = chk_d ? xor_d : shift_d[DATA_WIDTH-1:0];
`else
      data_d  = shift_d[DATA_WIDTH-1:0];
`endif
    end
  end

  // Ready only after a full IDLE cycle, so a word is never taken in the frame_done cycle.
  assign ready_d = (state_q == IDLE) && (state_d == IDLE);

  assign in_ready         = ready_q;
  assign tx_data_valid    = valid_q;
  assign tx_parallel_data = data_q;
  assign frame_done       = done_q;
  assign timeout_error    = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sequencer.sv
// ============================================================================
// tb_uart_tx_sequencer: directed, table-driven bench with a busy-handshake transmitter model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_sequencer;

`ifdef UART_TX_SEQ_CHECKSUM_EN
  localparam int NB_SENT = 3;
`else
  localparam int NB_SENT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        tx_data_valid;
  logic [7:0]  tx_parallel_data;
  logic        tx_busy = 1'b0;
  logic        frame_done;
  logic        timeout_error;

  uart_tx_sequencer #(
    .DATA_WIDTH    (8),
    .NUM_BYTES     (2),
    .ACCEPT_TIMEOUT(16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .tx_data_valid   (tx_data_valid),
    .tx_parallel_data(tx_parallel_data),
    .tx_busy         (tx_busy),
    .frame_done      (frame_done),
    .timeout_error   (timeout_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor plus transmitter model: busy rises one cycle after a valid pulse, held 10 cycles.
  logic [7:0] byte_q[$];
  int         vcyc_q[$];
  int         done_cnt = 0, tmo_cnt = 0, done_cyc = 0, tmo_cyc = 0, fall_cyc = 0;
  bit         model_en = 1'b1;
  bit         busy_pending = 1'b0;
  int         hold = 0;

  always @(negedge clk) begin
    if (tx_data_valid) begin
      check("no_valid_while_busy", {31'd0, tx_busy}, 32'd0);
      byte_q.push_back(tx_parallel_data);
      vcyc_q.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (timeout_error) begin
      tmo_cnt = tmo_cnt + 1;
      tmo_cyc = cyc;
    end
    if (busy_pending) begin
      tx_busy = 1'b1;
      hold = 10;
      busy_pending = 1'b0;
    end else if (hold > 0) begin
      hold = hold - 1;
      if (hold == 0) begin
        tx_busy = 1'b0;
        fall_cyc = cyc;
      end
    end
    if (tx_data_valid && model_en) busy_pending = 1'b1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, output int acc_cyc);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    check("send_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data = w;
    acc_cyc = cyc;
    tick();
    in_valid = 1'b0;
    in_data = 16'($urandom);
  endtask

  task automatic wait_end(input int base);
    int n = 0;
    while ((done_cnt + tmo_cnt) == base && n < 200) begin
      tick();
      n++;
    end
    check("wait_end", done_cnt + tmo_cnt - base, 32'd1);
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] cs, input int k);
    return (k == 0) ? b0 : (k == 1) ? b1 : cs;
  endfunction

  typedef struct {
    logic [15:0] word;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  cs;
  } vec_t;

  vec_t vecs[4];
  vec_t t6[3];

  initial begin
    int acc, d0, t0, n, idx;
    bit pend;

    vecs[0] = '{16'hA55A, 8'h5A, 8'hA5, 8'hFF};
    vecs[1] = '{16'h0102, 8'h02, 8'h01, 8'h03};
    vecs[2] = '{16'hFF00, 8'h00, 8'hFF, 8'hFF};
    vecs[3] = '{16'h1234, 8'h34, 8'h12, 8'h26};
    t6[0]   = '{16'h3C4B, 8'h4B, 8'h3C, 8'h77};
    t6[1]   = '{16'h8001, 8'h01, 8'h80, 8'h81};
    t6[2]   = '{16'h7E7E, 8'h7E, 8'h7E, 8'h00};

    // Reset held three cycles: every output low.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs", {20'd0, in_ready, tx_data_valid, tx_parallel_data, frame_done, timeout_error}, 32'd0);
    end
    reset = 1'b0;
    tick();
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Table-driven words with the handshaking transmitter model.
    for (int v = 0; v < 4; v++) begin
      byte_q.delete();
      vcyc_q.delete();
      d0 = done_cnt;
      t0 = tmo_cnt;
      send_word(vecs[v].word, acc);
      wait_end(d0 + t0);
      check("frame_done_count", done_cnt - d0, 32'd1);
      check("no_timeout", tmo_cnt - t0, 32'd0);
      check("byte_count", byte_q.size(), NB_SENT);
      for (int k = 0; k < byte_q.size() && k < NB_SENT; k++)
        check("byte_value", {24'd0, byte_q[k]}, {24'd0, exp_byte(vecs[v].b0, vecs[v].b1, vecs[v].cs, k)});
      if (vcyc_q.size() > 0) check("first_valid_latency", vcyc_q[0] - acc, 32'd1);
      check("done_after_busy_fall", done_cyc - fall_cyc, 32'd1);
      check("ready_low_on_done", {31'd0, in_ready}, 32'd0);
      tick();
      check("ready_after_done", {31'd0, in_ready}, 32'd1);
    end

    // Transmitter never accepts: decided on the 16th WAIT_ACCEPT cycle, flagged one cycle later.
    model_en = 1'b0;
    byte_q.delete();
    vcyc_q.delete();
    d0 = done_cnt;
    t0 = tmo_cnt;
    send_word(16'hBEEF, acc);
    wait_end(d0 + t0);
    check("timeout_count", tmo_cnt - t0, 32'd1);
    check("timeout_no_done", done_cnt - d0, 32'd0);
    check("timeout_one_byte", byte_q.size(), 32'd1);
    if (byte_q.size() > 0) check("timeout_byte", {24'd0, byte_q[0]}, 32'hEF);
    if (vcyc_q.size() > 0) check("timeout_delay", tmo_cyc - vcyc_q[0], 32'd17);
    check("ready_low_on_timeout", {31'd0, in_ready}, 32'd0);
    tick();
    check("ready_after_timeout", {31'd0, in_ready}, 32'd1);
    model_en = 1'b1;

    // Reset while the second byte is in WAIT_DONE.
    byte_q.delete();
    vcyc_q.delete();
    send_word(16'hCAFE, acc);
    n = 0;
    while (byte_q.size() < 2 && n < 100) begin
      tick();
      n++;
    end
    check("midreset_two_bytes", byte_q.size(), 32'd2);
    for (int i = 0; i < 4; i++) tick();
    d0 = done_cnt;
    t0 = tmo_cnt;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("midreset_no_more_bytes", byte_q.size(), 32'd2);
    check("midreset_no_done", done_cnt - d0, 32'd0);
    check("midreset_no_timeout", tmo_cnt - t0, 32'd0);
    byte_q.delete();
    vcyc_q.delete();
    d0 = done_cnt;
    send_word(16'h0102, acc);
    wait_end(d0 + tmo_cnt);
    check("postreset_done", done_cnt - d0, 32'd1);
    check("postreset_bytes", byte_q.size(), NB_SENT);
    if (byte_q.size() >= 2) begin
      check("postreset_b0", {24'd0, byte_q[0]}, 32'h02);
      check("postreset_b1", {24'd0, byte_q[1]}, 32'h01);
    end

    // in_valid held high across three words; in_data scrambled whenever not ready.
    byte_q.delete();
    vcyc_q.delete();
    d0 = done_cnt;
    idx = 0;
    pend = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 600 && idx < 3; c++) begin
      if (pend) begin
        idx++;
        pend = 1'b0;
      end
      if (idx < 3) begin
        in_data = in_ready ? t6[idx].word : 16'($urandom);
        if (in_ready) pend = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    check("stream_accepts", idx, 32'd3);
    n = 0;
    while (done_cnt - d0 < 3 && n < 200) begin
      tick();
      n++;
    end
    check("stream_done_count", done_cnt - d0, 32'd3);
    check("stream_byte_count", byte_q.size(), 3 * NB_SENT);
    for (int k = 0; k < byte_q.size() && k < 3 * NB_SENT; k++)
      check("stream_byte", {24'd0, byte_q[k]},
            {24'd0, exp_byte(t6[k / NB_SENT].b0, t6[k / NB_SENT].b1, t6[k / NB_SENT].cs, k % NB_SENT)});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
